// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/load-store arbiter onto a byte-serial core memory
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_rdata,
    output logic              fetch_done,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_done,
    output logic              busy,
    output logic              owner,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_cnt;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_fetch_rdata;
    logic [31:0]       r_lsu_rdata;

    logic              w_any_req;
    logic              w_grant_lsu;
    logic              w_in_xfer;
    logic [4:0]        w_byte_sel;

    // On a tie the requester that did not own the port last time wins.
    always_comb begin
        w_any_req = fetch_req | lsu_req;
        if (fetch_req && lsu_req) begin
            w_grant_lsu = ~r_owner;
        end else begin
            w_grant_lsu = lsu_req;
        end
    end

    assign w_in_xfer  = (r_state == S_XFER);
    assign w_byte_sel = {r_cnt, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_owner       <= 1'b1;
            r_we          <= 1'b0;
            r_base        <= '0;
            r_wdata       <= 32'd0;
            r_fetch_rdata <= 32'd0;
            r_lsu_rdata   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_lsu;
                        r_we    <= w_grant_lsu & lsu_we;
                        r_base  <= w_grant_lsu ? lsu_addr : fetch_addr;
                        r_wdata <= w_grant_lsu ? lsu_wdata : 32'd0;
                        r_cnt   <= 2'd0;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    // Reads overwrite the owner's word byte by byte; stores leave rdata alone.
                    if (!r_we) begin
                        if (r_owner) begin
                            r_lsu_rdata[w_byte_sel +: 8] <= mem_rdata;
                        end else begin
                            r_fetch_rdata[w_byte_sel +: 8] <= mem_rdata;
                        end
                    end
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Address arithmetic wraps naturally at 2^ADDR_W.
    assign mem_addr    = w_in_xfer ? (r_base + {{(ADDR_W-2){1'b0}}, r_cnt}) : '0;
    assign mem_we      = w_in_xfer & r_we;
    assign mem_wdata   = w_in_xfer ? r_wdata[w_byte_sel +: 8] : 8'd0;

    assign busy        = (r_state == S_XFER) | (r_state == S_DONE);
    assign owner       = r_owner;
    assign fetch_done  = (r_state == S_DONE) & ~r_owner;
    assign lsu_done    = (r_state == S_DONE) & r_owner;
    assign fetch_rdata = r_fetch_rdata;
    assign lsu_rdata   = r_lsu_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_rdata;
    logic        fetch_done;
    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        busy;
    logic        owner;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_rdata(fetch_rdata), .fetch_done(fetch_done),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
        .busy(busy), .owner(owner),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // 4 KiB memory model aliased on the low address bits; preload port shares the write process.
    logic [7:0]  mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;

    assign mem_rdata = mem[mem_addr[11:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    typedef struct {
        bit          who;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || fetch_done !== 1'b0 || lsu_done !== 1'b0) begin bad++; $display("FAIL reset_status busy=%b fd=%b ld=%b want 000", busy, fetch_done, lsu_done); end
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL reset_owner got=%b want=1", owner); end
        total++; if (fetch_rdata !== 32'd0 || lsu_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata f=%h l=%h want 0", fetch_rdata, lsu_rdata); end
        total++; if (mem_addr !== 32'd0 || mem_we !== 1'b0 || mem_wdata !== 8'd0) begin bad++; $display("FAIL reset_mem a=%h we=%b wd=%h want 0", mem_addr, mem_we, mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch_read;
        exp_t e;
        poke(12'hAEF, 8'h93); poke(12'hAF0, 8'h02); poke(12'hAF1, 8'hB0); poke(12'hAF2, 8'h07);
        fetch_addr = 32'h0000_0AEF; fetch_req = 1'b1;
        q.push_back('{1'b0, 32'h07B0_0293});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            fetch_addr = 32'h0;
            total++; if (mem_addr !== 32'h0AEF + 32'(k) || mem_we !== 1'b0 || fetch_done !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL fetch_byte%0d addr=%h we=%b done=%b busy=%b want addr=%h", k, mem_addr, mem_we, fetch_done, busy, 32'h0AEF + 32'(k)); end
        end
        @(negedge clk);
        total++; if (fetch_done !== 1'b1 || lsu_done !== 1'b0) begin bad++; $display("FAIL fetch_done fd=%b ld=%b want 10", fetch_done, lsu_done); end
        e = q.pop_front();
        total++; if (fetch_rdata !== e.data) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", fetch_rdata, e.data); end
        fetch_req = 1'b0;
        @(negedge clk);
        total++; if (fetch_done !== 1'b0 || busy !== 1'b0 || owner !== 1'b0) begin bad++; $display("FAIL fetch_after fd=%b busy=%b owner=%b want 0 0 0", fetch_done, busy, owner); end
    endtask

    task automatic test_wrap;
        exp_t e;
        logic [31:0] want;
        poke(12'hFFE, 8'h11); poke(12'hFFF, 8'h22); poke(12'h000, 8'h33); poke(12'h001, 8'h44);
        lsu_addr = 32'hFFFF_FFFE; lsu_we = 1'b0; lsu_req = 1'b1;
        q.push_back('{1'b1, 32'h4433_2211});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            want = 32'hFFFF_FFFE + 32'(k);
            total++; if (mem_addr !== want) begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", k, mem_addr, want); end
        end
        @(negedge clk);
        e = q.pop_front();
        total++; if (lsu_done !== 1'b1 || lsu_rdata !== e.data) begin bad++; $display("FAIL wrap_load done=%b got=%h want=%h", lsu_done, lsu_rdata, e.data); end
        lsu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store;
        logic [7:0] wb [4];
        wb[0] = 8'h58; wb[1] = 8'h00; wb[2] = 8'h00; wb[3] = 8'h00;
        for (int k = 0; k < 4; k++) poke(12'(123 + k), 8'hAA);
        lsu_addr = 32'd123; lsu_we = 1'b1; lsu_wdata = 32'd88; lsu_req = 1'b1;
        q.push_back('{1'b1, 32'h4433_2211});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lsu_wdata = 32'hFFFF_FFFF; lsu_we = 1'b0; lsu_addr = 32'd0;
            total++; if (mem_we !== 1'b1 || mem_wdata !== wb[k] || mem_addr !== 32'(123 + k)) begin
                bad++; $display("FAIL store_byte%0d we=%b wd=%h a=%h want we=1 wd=%h a=%0d", k, mem_we, mem_wdata, mem_addr, wb[k], 123 + k); end
        end
        @(negedge clk);
        total++; if (lsu_done !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL store_done ld=%b we=%b want 1 0", lsu_done, mem_we); end
        begin
            exp_t e;
            e = q.pop_front();
            total++; if (lsu_rdata !== e.data) begin bad++; $display("FAIL store_rdata_hold got=%h want=%h", lsu_rdata, e.data); end
        end
        lsu_req = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++; if (mem[123 + k] !== wb[k]) begin bad++; $display("FAIL store_mem%0d got=%h want=%h", k, mem[123 + k], wb[k]); end
        end
    endtask

    task automatic test_tie;
        int fd, ld;
        exp_t e;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int rep = 0; rep < 2; rep++) begin
            fetch_addr = 32'h0000_0AEF; lsu_addr = 32'hFFFF_FFFE; lsu_we = 1'b0;
            fetch_req = 1'b1; lsu_req = 1'b1;
            q.push_back('{1'b0, 32'h07B0_0293});
            q.push_back('{1'b1, 32'h4433_2211});
            fd = 0; ld = 0;
            for (int n = 1; n <= 14 && ld == 0; n++) begin
                @(negedge clk);
                if (fetch_done || lsu_done) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++; $display("FAIL tie_unexpected_done n=%0d", n);
                    end else begin
                        e = q.pop_front();
                        if (e.who !== lsu_done || (lsu_done ? lsu_rdata : fetch_rdata) !== e.data) begin
                            bad++; $display("FAIL tie_order rep=%0d n=%0d who=%b want=%b data=%h want=%h", rep, n, lsu_done, e.who, lsu_done ? lsu_rdata : fetch_rdata, e.data); end
                    end
                    if (fetch_done) begin fd = n; fetch_req = 1'b0; end
                    if (lsu_done) begin ld = n; lsu_req = 1'b0; end
                end
            end
            total++; if (fd !== 5 || ld !== 11) begin bad++; $display("FAIL tie_timing rep=%0d fetch_done_at=%0d lsu_done_at=%0d want 5 11", rep, fd, ld); end
            fetch_req = 1'b0; lsu_req = 1'b0;
            q.delete();
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int d1, d2, busy6;
        exp_t e;
        fetch_addr = 32'h0000_0AEF; fetch_req = 1'b1;
        q.push_back('{1'b0, 32'h07B0_0293});
        q.push_back('{1'b0, 32'h07B0_0293});
        d1 = 0; d2 = 0; busy6 = -1;
        for (int n = 1; n <= 14 && d2 == 0; n++) begin
            @(negedge clk);
            if (n == 6) busy6 = int'(busy);
            if (fetch_done) begin
                if (d1 == 0) d1 = n;
                else begin d2 = n; fetch_req = 1'b0; end
                e = q.pop_front();
                total++; if (fetch_rdata !== e.data) begin bad++; $display("FAIL b2b_rdata n=%0d got=%h want=%h", n, fetch_rdata, e.data); end
            end
        end
        total++; if (d1 !== 5 || d2 !== 11 || busy6 !== 0) begin bad++; $display("FAIL b2b_timing d1=%0d d2=%0d busy@6=%0d want 5 11 0", d1, d2, busy6); end
        fetch_req = 1'b0;
        q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int saw_done;
        for (int k = 0; k < 4; k++) poke(12'(200 + k), 8'hCC);
        lsu_addr = 32'd200; lsu_we = 1'b1; lsu_wdata = 32'h1234_5678; lsu_req = 1'b1;
        @(negedge clk);
        total++; if (mem_addr !== 32'd200 || mem_we !== 1'b1) begin bad++; $display("FAIL rstmid_first a=%h we=%b want c8 1", mem_addr, mem_we); end
        @(negedge clk);
        rst_n = 1'b0; lsu_req = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 8'd0 || lsu_done !== 1'b0) begin
            bad++; $display("FAIL rstmid_async busy=%b we=%b a=%h wd=%h ld=%b want all 0", busy, mem_we, mem_addr, mem_wdata, lsu_done); end
        total++; if (owner !== 1'b1 || lsu_rdata !== 32'd0 || fetch_rdata !== 32'd0) begin
            bad++; $display("FAIL rstmid_regs owner=%b l=%h f=%h want 1 0 0", owner, lsu_rdata, fetch_rdata); end
        saw_done = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (lsu_done) saw_done = 1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (lsu_done || busy) saw_done = 1;
        end
        total++; if (saw_done !== 0) begin bad++; $display("FAIL rstmid_no_done saw=%0d want 0", saw_done); end
        total++; if (mem[200] !== 8'h78 || mem[202] !== 8'hCC || mem[203] !== 8'hCC) begin
            bad++; $display("FAIL rstmid_mem m200=%h m202=%h m203=%h want 78 cc cc", mem[200], mem[202], mem[203]); end
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; lsu_req = 1'b0; lsu_we = 1'b0;
        lsu_addr = '0; lsu_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        @(negedge clk);
        test_reset;
        test_fetch_read;
        test_wrap;
        test_store;
        test_tie;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
